// File: rtl/act_feeder_if.sv
// DDR read-command/data channel plus the activation stream toward the DNN.
// The master modport is the feeder's side.
interface act_feeder_if #(
    parameter int DATA_W = 128
);
    logic              rd_req_o;
    logic [23:0]       rd_addr_o;
    logic              rd_req_ack_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              rd_data_valid_i;
    logic [DATA_W-1:0] act_o;
    logic              act_valid_o;
    logic              act_ready_i;

    modport master (
        output rd_req_o, rd_addr_o, act_o, act_valid_o,
        input  rd_req_ack_i, rd_data_i, rd_data_valid_i, act_ready_i
    );

    modport slave (
        input  rd_req_o, rd_addr_o, act_o, act_valid_o,
        output rd_req_ack_i, rd_data_i, rd_data_valid_i, act_ready_i
    );
endinterface

// File: rtl/act_feeder.sv
// Fetches NUM_BEATS DDR beats per run and streams them to the DNN through a
// first-word-fall-through FIFO; requests are credit-limited so the FIFO cannot overflow.
module act_feeder #(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 16,
    parameter int NUM_BEATS = 16384,
    parameter int ADDR_STEP = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_i,
    act_feeder_if.master bus,
    output logic         done_o,
    output logic         ovf_o
);
    localparam int CW = $clog2(NUM_BEATS) + 1;
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + FW + 2;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_req_cnt;
    logic [CW-1:0]      r_rcv_cnt;
    logic [FW-1:0]      r_fifo_cnt;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [23:0]        r_addr;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_start;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_rd_req;
    logic signed [SW-1:0] w_credit;

    // Outstanding requests can go negative when stray beats arrive, so credit is signed.
    assign w_credit = SW'(DEPTH) - SW'(r_fifo_cnt) - (SW'(r_req_cnt) - SW'(r_rcv_cnt));
    assign w_start  = (r_state == IDLE) && start_i;
    assign w_accept = w_rd_req && bus.rd_req_ack_i;
    assign w_full   = (r_fifo_cnt == FW'(DEPTH));
    assign w_pop    = (r_fifo_cnt != '0) && bus.act_ready_i;
    assign w_push   = bus.rd_data_valid_i && (!w_full || w_pop);

    assign bus.rd_req_o    = w_rd_req;
    assign bus.rd_addr_o   = r_addr;
    assign bus.act_valid_o = (r_fifo_cnt != '0);
    assign bus.act_o       = r_mem[r_rd_ptr];
    assign ovf_o           = r_ovf;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start_i) w_next = REQ;
            REQ:   if (w_accept && r_req_cnt == CW'(NUM_BEATS - 1)) w_next = DRAIN;
            DRAIN: if (r_rcv_cnt == CW'(NUM_BEATS) && r_fifo_cnt == '0) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_req = 1'b0;
        done_o   = 1'b0;
        case (r_state)
            REQ:  w_rd_req = !w_credit[SW-1] && (w_credit != '0) && (r_req_cnt < CW'(NUM_BEATS));
            DONE: done_o   = 1'b1;
            default: ;
        endcase
    end

    // Beats are counted even in IDLE so in-flight data after an abort is still accounted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
            r_addr    <= '0;
        end else if (w_start) begin
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
            r_addr    <= '0;
        end else begin
            if (w_accept) begin
                r_req_cnt <= r_req_cnt + CW'(1);
                r_addr    <= r_addr + 24'(ADDR_STEP);
            end
            if (bus.rd_data_valid_i) r_rcv_cnt <= r_rcv_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + FW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - FW'(1);
                default: ;
            endcase
            if (bus.rd_data_valid_i && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.rd_data_i;
    end
endmodule

// File: tb/tb_act_feeder.sv
// Directed bench for act_feeder: three instances cover the small-run, FIFO-credit
// and full-length random-stall cases against a fixed-latency DDR model.
module tb_act_feeder;
    localparam int WS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstnA, rstnB, rstnC;
    logic startA, startB, startC;
    logic doneA, doneB, doneC;
    logic ovfA, ovfB, ovfC;

    act_feeder_if #(.DATA_W(WS))  bA ();
    act_feeder_if #(.DATA_W(WS))  bB ();
    act_feeder_if #(.DATA_W(128)) bC ();

    act_feeder #(.DATA_W(WS), .DEPTH(4), .NUM_BEATS(4), .ADDR_STEP(8)) u_a (
        .clk(clk), .rstn(rstnA), .start_i(startA), .bus(bA.master), .done_o(doneA), .ovf_o(ovfA));
    act_feeder #(.DATA_W(WS), .DEPTH(4), .NUM_BEATS(12), .ADDR_STEP(8)) u_b (
        .clk(clk), .rstn(rstnB), .start_i(startB), .bus(bB.master), .done_o(doneB), .ovf_o(ovfB));
    act_feeder u_c (
        .clk(clk), .rstn(rstnC), .start_i(startC), .bus(bC.master), .done_o(doneC), .ovf_o(ovfC));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ddr_word(input logic [23:0] a);
        return {8'hC3, a, 8'h5A, ~a, 8'h96, a ^ 24'h00F0F0, 8'h3C, a + 24'd1};
    endfunction

    function automatic logic [WS-1:0] ddr_lo(input logic [23:0] a);
        logic [127:0] w;
        w = ddr_word(a);
        return w[WS-1:0];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // DDR model: each accepted request returns its data 3 cycles later.
    logic [2:0]    dvA = '0, dvB = '0, dvC = '0;
    logic [23:0]   daA [3] = '{default: '0};
    logic [23:0]   daB [3] = '{default: '0};
    logic [23:0]   daC [3] = '{default: '0};
    logic [WS-1:0] wA = '0, wB = '0, frcD = '0;
    logic [127:0]  wC = '0;
    logic          frcB = 1'b0;
    logic          enB  = 1'b1;
    logic          enC  = 1'b0;
    int            accA = 0, accB = 0;

    assign bA.rd_data_valid_i = dvA[2];
    assign bA.rd_data_i       = wA;
    assign bB.rd_data_valid_i = dvB[2] | frcB;
    assign bB.rd_data_i       = frcB ? frcD : wB;
    assign bC.rd_data_valid_i = dvC[2];
    assign bC.rd_data_i       = wC;

    always @(posedge clk) begin : resp
        logic acc_a, acc_b, acc_c;
        logic [23:0] ad_a, ad_b, ad_c;
        acc_a = bA.rd_req_o && bA.rd_req_ack_i;
        acc_b = bB.rd_req_o && bB.rd_req_ack_i;
        acc_c = bC.rd_req_o && bC.rd_req_ack_i;
        ad_a  = bA.rd_addr_o;
        ad_b  = bB.rd_addr_o;
        ad_c  = bC.rd_addr_o;
        if (acc_a) begin
            chk("A_req_addr", 128'(ad_a), 128'(accA * 8));
            accA++;
        end
        if (acc_b) begin
            chk("B_req_addr", 128'(ad_b), 128'(accB * 8));
            accB++;
        end
        #1;
        dvA = {dvA[1:0], acc_a}; daA[2] = daA[1]; daA[1] = daA[0]; daA[0] = ad_a; wA = ddr_lo(daA[2]);
        dvB = {dvB[1:0], acc_b}; daB[2] = daB[1]; daB[1] = daB[0]; daB[0] = ad_b; wB = ddr_lo(daB[2]);
        dvC = {dvC[1:0], acc_c}; daC[2] = daC[1]; daC[1] = daC[0]; daC[0] = ad_c; wC = ddr_word(daC[2]);
        if (enC) begin
            bC.rd_req_ack_i = ($urandom_range(0, 9) < 7);
            bC.act_ready_i  = ($urandom_range(0, 9) < 6);
        end
    end

    // Activation monitor: every popped word must be the next DDR word in address order.
    int beatA = 0, beatB = 0, beatC = 0;
    int dnA = 0, dnB = 0, dnC = 0;

    always @(negedge clk) begin
        if (bA.act_valid_o === 1'b1 && bA.act_ready_i) begin
            chk("A_act", 128'(bA.act_o), 128'(ddr_lo(24'(beatA * 8))));
            beatA++;
        end
        if (enB && bB.act_valid_o === 1'b1 && bB.act_ready_i) begin
            chk("B_act", 128'(bB.act_o), 128'(ddr_lo(24'(beatB * 8))));
            beatB++;
        end
        if (bC.act_valid_o === 1'b1 && bC.act_ready_i) begin
            chk("C_act", bC.act_o, ddr_word(24'(beatC * 8)));
            beatC++;
        end
        if (doneA === 1'b1) dnA++;
        if (doneB === 1'b1) dnB++;
        if (doneC === 1'b1) dnC++;
    end

    logic [WS-1:0] expB [4];
    int            sv_acc;

    initial begin
        rstnA = 1'b0; rstnB = 1'b0; rstnC = 1'b0;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        bA.rd_req_ack_i = 1'b0; bA.act_ready_i = 1'b0;
        bB.rd_req_ack_i = 1'b0; bB.act_ready_i = 1'b0;
        bC.rd_req_ack_i = 1'b0; bC.act_ready_i = 1'b0;
        step(3);
        @(negedge clk);
        chk("A_rst_req",  128'(bA.rd_req_o),    128'(0));
        chk("A_rst_addr", 128'(bA.rd_addr_o),   128'(0));
        chk("A_rst_vld",  128'(bA.act_valid_o), 128'(0));
        chk("A_rst_done", 128'(doneA),          128'(0));
        chk("A_rst_ovf",  128'(ovfA),           128'(0));
        step(1);
        rstnA = 1'b1; rstnB = 1'b1; rstnC = 1'b1;
        step(2);

        // Short run, ack always high, DNN always ready.
        bA.rd_req_ack_i = 1'b1; bA.act_ready_i = 1'b1; startA = 1'b1;
        step(1);
        startA = 1'b0;
        for (int i = 0; i < 100 && dnA == 0; i++) step(1);
        step(5);
        chk("A_done_cnt", 128'(dnA),  128'(1));
        chk("A_reqs",     128'(accA), 128'(4));
        chk("A_beats",    128'(beatA), 128'(4));
        chk("A_ovf",      128'(ovfA), 128'(0));
        @(negedge clk);
        chk("A_idle_req", 128'(bA.rd_req_o), 128'(0));

        // DNN stalled: credit must stop requests at FIFO depth.
        step(1);
        bB.rd_req_ack_i = 1'b1; bB.act_ready_i = 1'b0; startB = 1'b1;
        step(1);
        startB = 1'b0;
        step(30);
        @(negedge clk);
        chk("B_stall_reqs", 128'(accB),           128'(4));
        chk("B_stall_req",  128'(bB.rd_req_o),    128'(0));
        chk("B_stall_vld",  128'(bB.act_valid_o), 128'(1));
        chk("B_stall_ovf",  128'(ovfB),           128'(0));
        step(1);
        bB.act_ready_i = 1'b1;
        for (int i = 0; i < 20 && accB <= 4; i++) step(1);
        chk("B_resume", 128'(accB > 4), 128'(1));

        // Controller withholds ack: request and address must hold.
        for (int i = 0; i < 20 && bB.rd_req_o !== 1'b1; i++) step(1);
        bB.rd_req_ack_i = 1'b0;
        sv_acc = accB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("B_hold_req",  128'(bB.rd_req_o),  128'(1));
            chk("B_hold_addr", 128'(bB.rd_addr_o), 128'(sv_acc * 8));
        end
        chk("B_hold_cnt", 128'(accB), 128'(sv_acc));
        step(1);
        bB.rd_req_ack_i = 1'b1;
        for (int i = 0; i < 200 && dnB == 0; i++) step(1);
        step(3);
        chk("B_done_cnt", 128'(dnB),   128'(1));
        chk("B_reqs",     128'(accB),  128'(12));
        chk("B_beats",    128'(beatB), 128'(12));
        chk("B_ovf",      128'(ovfB),  128'(0));

        // Fill FIFO, then push+pop in the same cycle, then push into full FIFO.
        enB = 1'b0; accB = 0;
        bB.act_ready_i = 1'b0; bB.rd_req_ack_i = 1'b1; startB = 1'b1;
        step(1);
        startB = 1'b0;
        step(12);
        bB.rd_req_ack_i = 1'b0;
        @(negedge clk);
        chk("B_full_vld",  128'(bB.act_valid_o), 128'(1));
        chk("B_full_req",  128'(bB.rd_req_o),    128'(0));
        chk("B_full_head", 128'(bB.act_o),       128'(ddr_lo(24'd0)));
        step(1);
        frcB = 1'b1; frcD = 32'hF00D_0001; bB.act_ready_i = 1'b1;
        step(1);
        frcB = 1'b0; bB.act_ready_i = 1'b0;
        @(negedge clk);
        chk("B_pp_ovf",  128'(ovfB),           128'(0));
        chk("B_pp_vld",  128'(bB.act_valid_o), 128'(1));
        chk("B_pp_head", 128'(bB.act_o),       128'(ddr_lo(24'd8)));
        step(1);
        frcB = 1'b1; frcD = 32'hF00D_0002;
        step(1);
        frcB = 1'b0;
        @(negedge clk);
        chk("B_ovf_set",  128'(ovfB),     128'(1));
        chk("B_ovf_head", 128'(bB.act_o), 128'(ddr_lo(24'd8)));
        expB[0] = ddr_lo(24'd8);
        expB[1] = ddr_lo(24'd16);
        expB[2] = ddr_lo(24'd24);
        expB[3] = 32'hF00D_0001;
        step(1);
        bB.act_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("B_drain_vld",  128'(bB.act_valid_o), 128'(1));
            chk("B_drain_data", 128'(bB.act_o),       128'(expB[k]));
        end
        @(negedge clk);
        chk("B_empty",      128'(bB.act_valid_o), 128'(0));
        chk("B_ovf_sticky", 128'(ovfB),           128'(1));

        // start_i during REQ is ignored; reset mid-run aborts.
        step(1);
        bB.act_ready_i = 1'b0; startB = 1'b1;
        step(1);
        startB = 1'b0;
        @(negedge clk);
        chk("B_start_ign_addr", 128'(bB.rd_addr_o), 128'(32));
        chk("B_start_ign_req",  128'(bB.rd_req_o),  128'(1));
        step(1);
        frcB = 1'b1; frcD = 32'hF00D_0003;
        step(1);
        frcB = 1'b0;
        @(negedge clk);
        chk("B_pre_rst_vld", 128'(bB.act_valid_o), 128'(1));
        step(1);
        rstnB = 1'b0;
        step(1);
        @(negedge clk);
        chk("B_rst_req",  128'(bB.rd_req_o),    128'(0));
        chk("B_rst_addr", 128'(bB.rd_addr_o),   128'(0));
        chk("B_rst_vld",  128'(bB.act_valid_o), 128'(0));
        chk("B_rst_done", 128'(doneB),          128'(0));
        chk("B_rst_ovf",  128'(ovfB),           128'(0));
        chk("B_no_done",  128'(dnB),            128'(1));
        step(1);
        rstnB = 1'b1;

        // Full-length run with random ack and ready stalls.
        step(2);
        enC = 1'b1; startC = 1'b1;
        step(1);
        startC = 1'b0;
        for (int i = 0; i < 80000 && dnC == 0; i++) step(1);
        enC = 1'b0;
        step(5);
        chk("C_done_cnt", 128'(dnC),   128'(1));
        chk("C_beats",    128'(beatC), 128'(16384));
        chk("C_ovf",      128'(ovfC),  128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter DATA_W, default 128, width of one DDR read beat and of one activation word.
REQ-002 Parameter DEPTH, default 16, power of two, activation FIFO entries.
REQ-003 Parameter NUM_BEATS, default 16384, beats fetched per run.
REQ-004 Parameter ADDR_STEP, default 8, DDR address increment per beat.
REQ-005 clk  in  1  single clock (DDR UI clock domain); all logic on posedge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 start_i  in  1  one-cycle pulse starting a run.
REQ-008 rd_req_o  out  1  read command request to DDR controller, one beat per accepted request.
REQ-009 rd_addr_o  out  24  DDR address of the current request.
REQ-010 rd_req_ack_i  in  1  controller accepts request this cycle.
REQ-011 rd_data_i  in  DATA_W  DDR read data.
REQ-012 rd_data_valid_i  in  1  rd_data_i valid this cycle; no backpressure.
REQ-013 act_o  out  DATA_W  activation word to DNN (FIFO head).
REQ-014 act_valid_o  out  1  act_o valid.
REQ-015 act_ready_i  in  1  DNN consumes act_o this cycle.
REQ-016 done_o  out  1  one-cycle pulse, run complete.
REQ-017 ovf_o  out  1  sticky error: valid beat arrived with FIFO full.

Function
REQ-018 FSM states IDLE, REQ, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start_i=1 -> REQ next cycle; req_cnt, rcv_cnt, rd_addr_o cleared to 0; FIFO not flushed.
REQ-020 start_i SHALL be ignored in REQ, DRAIN, DONE.
REQ-021 Request accepted when rd_req_o=1 and rd_req_ack_i=1; then req_cnt+1, rd_addr_o+ADDR_STEP next cycle (24-bit wrap).
REQ-022 rd_req_o SHALL be 1 in REQ only when credit>0, credit = DEPTH - fifo_count - (req_cnt - rcv_cnt), all computed from registered values.
REQ-023 rd_req_o and rd_addr_o SHALL hold stable until acknowledged.
REQ-024 REQ -> DRAIN in the cycle after acceptance of request NUM_BEATS-1.
REQ-025 Each rd_data_valid_i=1 pushes rd_data_i and increments rcv_cnt, in any state.
REQ-026 FIFO first-word fall-through: act_valid_o = (fifo_count!=0); act_o = head entry; pop when act_valid_o && act_ready_i.
REQ-027 Simultaneous push and pop: fifo_count unchanged; push into full FIFO allowed only if pop same cycle.
REQ-028 Push into full FIFO without pop: beat dropped, ovf_o set to 1 until reset.
REQ-029 DRAIN -> DONE when rcv_cnt==NUM_BEATS and fifo_count==0.
REQ-030 DONE: done_o=1 for exactly that cycle; -> IDLE next cycle.
REQ-031 Counters req_cnt, rcv_cnt SHALL be $clog2(NUM_BEATS)+1 bits; fifo_count $clog2(DEPTH)+1 bits.

Reset
REQ-032 rstn=0 at posedge: state IDLE, rd_req_o=0, rd_addr_o=0, act_valid_o=0, done_o=0, ovf_o=0, counters and FIFO pointers 0.
REQ-033 Reset mid-run SHALL abort immediately; in-flight beats arriving after reset release in IDLE are pushed (REQ-025) and presented to DNN.
REQ-034 act_o value SHALL be don't-care while act_valid_o=0.

Verification
REQ-035 NUM_BEATS=4, ack always 1, valid 3 cycles after each ack, act_ready_i=1 -> 4 requests at addr 0,8,16,24; 4 act_o beats in order; done_o once; ovf_o=0.
REQ-036 DEPTH=4, act_ready_i=0 -> exactly 4 requests issued, rd_req_o then 0; after act_ready_i=1 requests resume; no overflow.
REQ-037 rd_req_ack_i held 0 for 10 cycles -> rd_req_o=1, rd_addr_o constant throughout; req_cnt unchanged.
REQ-038 FIFO full, push and pop same cycle -> fifo_count stays DEPTH, ovf_o=0; forced push into full FIFO with act_ready_i=0 -> ovf_o=1 and stays 1.
REQ-039 start_i pulsed again during REQ -> ignored, counts unchanged; rstn=0 mid-REQ -> all outputs per REQ-032 next cycle.
REQ-040 NUM_BEATS=16384, random ack/ready stalls -> 16384 beats delivered in order matching DDR model contents, single done_o.
